seq_counter: RTL and testbench

- Free-running synchronous sequence counter with a single output vector Q.
- Default configuration is a 4-bit binary up-counter that wraps from 15 to 0.
- A compile-time MODE parameter selects one of four count sequences: binary, Gray, Johnson, or one-hot ring.
- Used as a generic timebase or sequencer; no enable or load inputs, so it counts on every clock.

---
 rtl/seq_counter.sv | 58 +++++
 tb/tb_seq_counter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/seq_counter.sv
// Free-running sequence counter: binary, Gray, Johnson or one-hot ring, selected by MODE.
// Illegal Johnson/ring states fall back to the reset value on the next edge.
module seq_counter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned MODE  = 0
) (
  input  logic             CLK,
  input  logic             RESET,
  output logic [WIDTH-1:0] Q
);

  localparam int unsigned W = WIDTH;
  localparam logic [W-1:0] ONE     = W'(1);
  localparam logic [W-1:0] ZERO    = W'(0);
  localparam logic [W-1:0] RST_VAL = (MODE == 3) ? ONE : ZERO;

  // Declaration initialisers keep Q defined before the first reset edge.
  logic [W-1:0] q_r = RST_VAL;
  logic [W-1:0] b_r = ZERO;
  logic [W-1:0] q_nxt;
  logic [W-1:0] b_nxt;
  logic [W-1:0] q_inv;
  logic         johnson_ok;
  logic         ring_ok;

  // Legal Johnson states are ones filled from bit 0 or from the MSB.
  always_comb begin
    q_inv      = ~q_r;
    johnson_ok = ((q_r & W'(q_r + ONE)) == ZERO) ||
                 ((q_inv & W'(q_inv + ONE)) == ZERO);
    ring_ok    = (q_r != ZERO) && ((q_r & W'(q_r - ONE)) == ZERO);
  end

  // Next-state selection per sequence.
  always_comb begin
    b_nxt = W'(b_r + ONE);
    q_nxt = W'(q_r + ONE);
    case (MODE)
      1: q_nxt = b_nxt ^ (b_nxt >> 1);
      2: q_nxt = johnson_ok ? {q_r[W-2:0], ~q_r[W-1]} : ZERO;
      3: q_nxt = ring_ok ? {q_r[W-2:0], q_r[W-1]} : ONE;
      default: q_nxt = W'(q_r + ONE);
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      q_r <= RST_VAL;
      b_r <= ZERO;
    end else begin
      q_r <= q_nxt;
      b_r <= b_nxt;
    end
  end

  assign Q = q_r;

endmodule

// File: tb/tb_seq_counter.sv
// Randomised bench for seq_counter: five instances (modes 0,1,2,3 and out-of-range 7)
// checked against a step-index model of each sequence.
`timescale 1ns/1ps
module tb_seq_counter;

  localparam int unsigned W    = 4;
  localparam int unsigned NDUT = 5;

  logic         CLK   = 1'b0;
  logic         RESET = 1'b0;
  logic [W-1:0] q0, q1, q2, q3, q7;

  seq_counter #(.WIDTH(W), .MODE(0)) dut_b (.CLK(CLK), .RESET(RESET), .Q(q0));
  seq_counter #(.WIDTH(W), .MODE(1)) dut_g (.CLK(CLK), .RESET(RESET), .Q(q1));
  seq_counter #(.WIDTH(W), .MODE(2)) dut_j (.CLK(CLK), .RESET(RESET), .Q(q2));
  seq_counter #(.WIDTH(W), .MODE(3)) dut_r (.CLK(CLK), .RESET(RESET), .Q(q3));
  seq_counter #(.WIDTH(W), .MODE(7)) dut_x (.CLK(CLK), .RESET(RESET), .Q(q7));

  // 20 us period
  always #10000 CLK = ~CLK;

  int vectors = 0;
  int errors  = 0;
  int k[NDUT];
  bit bad[NDUT];
  int modes[NDUT] = '{0, 1, 2, 3, 0};

  // Expected output at step s of a sequence, computed from the sequence definitions.
  function automatic logic [W-1:0] expv(input int m, input int s);
    int i;
    case (m)
      1: begin
        i = s % 16;
        return W'(i ^ (i >> 1));
      end
      2: begin
        i = s % (2 * W);
        if (i <= int'(W)) return W'((1 << i) - 1);
        else return W'(4'hF << (i - int'(W)));
      end
      3: return W'(1 << (s % int'(W)));
      default: return W'(s % 16);
    endcase
  endfunction

  function automatic int find_step(input int m, input logic [W-1:0] v);
    for (int j = 0; j < 16; j++)
      if (expv(m, j) == v) return j;
    return -1;
  endfunction

  function automatic logic [W-1:0] qv(input int i);
    case (i)
      0: return q0;
      1: return q1;
      2: return q2;
      3: return q3;
      default: return q7;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < int'(NDUT); i++)
      check($sformatf("%s dut%0d", tag, i), 32'(qv(i)), 32'(expv(modes[i], k[i])));
  endtask

  // Called just after a falling edge: drive RESET, optionally pulse it low between edges,
  // advance the model at the rising edge, compare at the next falling edge.
  task automatic cycle(input string tag, input logic rst, input bit glitch);
    RESET = rst;
    if (glitch && rst) begin
      #2500;
      RESET = 1'b0;
      #5000;
      RESET = 1'b1;
    end
    @(posedge CLK);
    for (int i = 0; i < int'(NDUT); i++) begin
      if (!rst || bad[i]) begin
        k[i]   = 0;
        bad[i] = 1'b0;
      end else begin
        k[i]++;
      end
    end
    @(negedge CLK);
    check_all(tag);
  endtask

  task automatic deposit(input int i, input logic [W-1:0] v);
    int s;
    if (i == 2) dut_j.q_r = v;
    else        dut_r.q_r = v;
    s = find_step(modes[i], v);
    if (s < 0) begin
      bad[i] = 1'b1;
    end else begin
      k[i]   = s;
      bad[i] = 1'b0;
    end
  endtask

  initial begin
    logic [W-1:0] prev;
    logic         rst;
    bit           gl;
    for (int i = 0; i < int'(NDUT); i++) begin
      k[i]   = 0;
      bad[i] = 1'b0;
    end

    #1;
    check("powerup_x", 32'($isunknown({q0, q1, q2, q3, q7})), 32'd0);
    check_all("powerup");

    @(negedge CLK);
    check_all("reset");
    cycle("reset_hold", 1'b0, 1'b0);

    // Release: 17 edges cover full binary/Gray periods plus the wrap.
    for (int n = 0; n < 17; n++) begin
      prev = q1;
      cycle("release", 1'b1, 1'b0);
      check("gray_onebit", 32'($countones(q1 ^ prev)), 32'd1);
    end
    check("bin_wrap", 32'(q0), 32'd1);

    // Mid-count reset at Q=9.
    for (int n = 0; n < 8; n++) cycle("to9", 1'b1, 1'b0);
    check("at9", 32'(q0), 32'd9);
    cycle("mid_rst", 1'b0, 1'b0);
    check("mid_rst_q", 32'(q0), 32'd0);
    cycle("post_rst", 1'b1, 1'b0);
    check("post_rst_q", 32'(q0), 32'd1);

    // Reset pulse strictly between edges at Q=5 is ignored.
    for (int n = 0; n < 4; n++) cycle("to5", 1'b1, 1'b0);
    check("at5", 32'(q0), 32'd5);
    cycle("glitch", 1'b1, 1'b1);
    check("glitch_q6", 32'(q0), 32'd6);
    cycle("after_glitch", 1'b1, 1'b0);
    check("glitch_q7", 32'(q0), 32'd7);

    // Self-correction from illegal states.
    cycle("rst2", 1'b0, 1'b0);
    deposit(2, 4'h5);
    deposit(3, 4'h3);
    cycle("illegal", 1'b1, 1'b0);
    check("johnson_fix", 32'(q2), 32'd0);
    check("ring_fix", 32'(q3), 32'd1);
    cycle("ring_next", 1'b1, 1'b0);
    check("ring_after_fix", 32'(q3), 32'd2);

    // Random reset, glitch pulses and state deposits.
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 15) != 0);
      gl  = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 19) == 0) deposit(2, W'($urandom_range(0, 15)));
      if ($urandom_range(0, 19) == 0) deposit(3, W'($urandom_range(0, 15)));
      cycle("random", rst, gl);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
